// File: rtl/fs_ds_inst_queue_if.sv
// IF -> instruction queue -> ID handshake and payload bundle.
// master drives the IF beat and ID's accept; slave is the queue itself.
interface fs_ds_inst_queue_if #(
   parameter int BUS_WD = 103
);
   logic              fs_to_iq_valid;
   logic [BUS_WD-1:0] fs_to_iq_bus;
   logic              iq_allowin;
   logic              iq_to_ds_valid;
   logic [BUS_WD-1:0] iq_to_ds_bus;
   logic              ds_allowin;

   modport master (
      output fs_to_iq_valid,
      output fs_to_iq_bus,
      output ds_allowin,
      input  iq_allowin,
      input  iq_to_ds_valid,
      input  iq_to_ds_bus
   );

   modport slave (
      input  fs_to_iq_valid,
      input  fs_to_iq_bus,
      input  ds_allowin,
      output iq_allowin,
      output iq_to_ds_valid,
      output iq_to_ds_bus
   );
endinterface

// File: rtl/fs_ds_inst_queue.sv
// In-order IF->ID instruction queue (circular buffer), emptied on exception/eret redirect.
// Optional macro IQ_BYPASS_EN: an empty queue hands the incoming beat straight to ID.
module fs_ds_inst_queue #(
   parameter int BUS_WD = 103,
   parameter int DEPTH  = 4,
   parameter int CNT_WD = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   fs_ds_inst_queue_if.slave iq_if,
   output logic [CNT_WD-1:0] iq_count_o
);
   localparam int PTR_WD = $clog2(DEPTH);

   logic [BUS_WD-1:0] mem_q [DEPTH];
   logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_WD-1:0] count_q,  count_d;

   logic empty_s;
   logic full_s;
   logic bypass_s;
   logic q_valid_s;
   logic push_s;
   logic pop_s;

   assign empty_s = (count_q == CNT_WD'(0));
   assign full_s  = (count_q == CNT_WD'(DEPTH));

`ifdef IQ_BYPASS_EN
   assign bypass_s = empty_s & iq_if.fs_to_iq_valid & ~flush_i & iq_if.ds_allowin;
`else
   assign bypass_s = 1'b0;
`endif

   // A pop in the same cycle frees the slot, so a full queue still accepts when ID takes the head.
   assign iq_if.iq_allowin = ~flush_i & (~full_s | iq_if.ds_allowin);
   assign q_valid_s        = ~flush_i & ~empty_s;
   assign iq_if.iq_to_ds_valid = q_valid_s | bypass_s;

   assign push_s = iq_if.fs_to_iq_valid & iq_if.iq_allowin & ~flush_i & ~bypass_s;
   assign pop_s  = q_valid_s & iq_if.ds_allowin;

   assign iq_count_o = count_q;

   // Head payload to ID: bypassed beat, stored head, or zero when empty.
   always_comb begin
      iq_if.iq_to_ds_bus = '0;
      if (bypass_s) begin
         iq_if.iq_to_ds_bus = iq_if.fs_to_iq_bus;
      end else if (empty_s) begin
         iq_if.iq_to_ds_bus = '0;
      end else begin
         iq_if.iq_to_ds_bus = mem_q[rd_ptr_q];
      end
   end

   // Occupancy next state: flush clears, otherwise pointers advance on push/pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_WD'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_WD'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_WD'(1);
            2'b01:   count_d = count_q - CNT_WD'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Occupancy registers; reset takes priority over flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array holds payload only and is deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= iq_if.fs_to_iq_bus;
      end
   end
endmodule
